// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC sequencing, credit-limited instruction memory reads
// and an in-order {pc, word} buffer presented to the decoder; redirects flush it.
module instr_fetch_unit #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int unsigned XW = 32;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   typedef enum logic {BOOT, RUN} state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] pc_q;
   logic [CW-1:0] outstanding_q;
   logic [CW-1:0] drop_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW-1:0] tag_wr_q, tag_rd_q;
   logic [XW-1:0] fifo_pc_q   [FIFO_DEPTH];
   logic [XW-1:0] fifo_word_q [FIFO_DEPTH];
   logic [XW-1:0] tag_q       [FIFO_DEPTH];
   logic          credit_ok;
   logic          rvalid_ok;
   logic          push;
   logic          pop;
   logic          unused_redirect_lsb;

   always_ff @(posedge clk) begin
      if (rst) state_q <= BOOT;
      else     state_q <= state_d;
   end

   // Requests only in RUN, never during a redirect, and only while a buffer slot is unclaimed.
   always_comb begin
      state_d   = state_q;
      imem_req  = 1'b0;
      credit_ok = (SW'(outstanding_q) + SW'(count_q)) < SW'(FIFO_DEPTH);
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     imem_req = !rst && !redirect_valid && credit_ok;
         default: state_d = BOOT;
      endcase
   end

   assign imem_addr           = pc_q;
   assign rvalid_ok           = imem_rvalid && (outstanding_q != '0);
   assign push                = rvalid_ok && (drop_q == '0) && !redirect_valid;
   assign pop                 = instr_valid && instr_ready && !redirect_valid;
   assign instr_valid         = (count_q != '0);
   assign instruction         = fifo_word_q[rd_ptr_q];
   assign instr_pc            = fifo_pc_q[rd_ptr_q];
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // PC tags of in-flight requests; stale responses still consume their tag.
   always_ff @(posedge clk) begin
      if (imem_req) tag_q[tag_wr_q] <= pc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         tag_wr_q      <= '0;
         tag_rd_q      <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc_q[i]   <= '0;
            fifo_word_q[i] <= '0;
         end
      end else begin
         if (redirect_valid) pc_q <= {redirect_pc[31:2], 2'b00};
         else if (imem_req)  pc_q <= pc_q + 32'd4;

         outstanding_q <= outstanding_q + CW'(imem_req) - CW'(rvalid_ok);

         if (imem_req)  tag_wr_q <= tag_wr_q + PW'(1);
         if (rvalid_ok) tag_rd_q <= tag_rd_q + PW'(1);

         // Everything still in flight at a redirect is stale.
         if (redirect_valid)                 drop_q <= outstanding_q - CW'(rvalid_ok);
         else if (rvalid_ok && drop_q != '0) drop_q <= drop_q - CW'(1);

         if (push) begin
            fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
            fifo_word_q[wr_ptr_q] <= imem_rdata;
            wr_ptr_q              <= wr_ptr_q + PW'(1);
         end

         if (redirect_valid) begin
            count_q  <= '0;
            rd_ptr_q <= wr_ptr_q;
         end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
         end
      end
   end

   // Responses to requests issued before a reset may still drain during BOOT.
   a_rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
      (imem_rvalid && state_q == RUN) |-> (outstanding_q != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with random latency and a
// queue-based reference of the fetch stream, compared every cycle.
module tb_instr_fetch_unit;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   instr_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; bit stale; } infl_t;

   mreq_t       mq[$];
   infl_t       m_infl[$];
   logic [31:0] m_fifo[$];
   logic [31:0] m_pc;
   bit          m_run;
   int          cyc_n, last_due, lat_min, lat_max;
   bit          hold;
   int          checks = 0;
   int          errors = 0;
   logic [97:0] obs_v, exp_v;
   logic        obs_req, obs_valid;
   logic [31:0] obs_addr, obs_head, obs_instr;
   bit          obs_rsp;
   int          obs_cyc;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
   endfunction

   // One clock cycle: drive inputs, sample outputs vs the reference, then advance memory and reference.
   task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
      bit          rsp, e_req, e_valid;
      logic [31:0] e_pc;
      infl_t       e;
      mreq_t       m;
      int          due;
      rst = r; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
      rsp = 1'b0;
      if (!hold && mq.size() != 0) rsp = (mq[0].due <= cyc_n);
      imem_rvalid = rsp;
      imem_rdata  = $urandom;
      if (rsp) imem_rdata = memw(mq[0].addr);
      @(negedge clk);
      e_valid = (m_fifo.size() != 0);
      e_pc    = 32'h0;
      if (e_valid) e_pc = m_fifo[0];
      e_req   = !r && m_run && !rv && ((m_infl.size() + m_fifo.size()) < DEPTH);
      exp_v   = {e_req, m_pc, e_valid, e_pc, e_valid ? memw(e_pc) : 32'h0};
      obs_v   = {imem_req, imem_addr, instr_valid,
                 instr_valid ? instr_pc : 32'h0, instr_valid ? instruction : 32'h0};
      obs_req = imem_req; obs_addr = imem_addr; obs_valid = instr_valid;
      obs_head = instr_pc; obs_instr = instruction; obs_rsp = rsp; obs_cyc = cyc_n;
      @(posedge clk);
      if (rsp) void'(mq.pop_front());
      if (obs_req === 1'b1) begin
         due = cyc_n + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         m.addr = obs_addr; m.due = due;
         mq.push_back(m);
         last_due = due;
      end
      if (r) begin
         m_infl.delete(); m_fifo.delete();
         m_pc = RPC; m_run = 1'b0; cyc_n = 0; last_due = -1;
      end else begin
         if (rv) begin
            m_fifo.delete();
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
            if (rsp && m_infl.size() != 0) void'(m_infl.pop_front());
         end else begin
            if (e_valid && rdy) void'(m_fifo.pop_front());
            if (rsp && m_infl.size() != 0) begin
               e = m_infl.pop_front();
               if (!e.stale) m_fifo.push_back(e.pc);
            end
            if (e_req) begin
               e.pc = m_pc; e.stale = 1'b0;
               m_infl.push_back(e);
               m_pc = m_pc + 32'd4;
            end
         end
         m_run = 1'b1;
         cyc_n++;
      end
      #1;
   endtask

   task automatic do_reset();
      mq.delete();
      hold = 1'b0;
      step(1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic test_reset();
      int nvalid = 0;
      lat_min = 1; lat_max = 1;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL reset_stream cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
         if (i == 0) begin
            checks++;
            if (obs_req !== 1'b0 || obs_addr !== RPC || obs_valid !== 1'b0 ||
                obs_head !== 32'h0 || obs_instr !== 32'h0) begin
               errors++;
               $display("FAIL boot_values got req=%b addr=%h v=%b pc=%h ins=%h exp 0/%h/0/0/0",
                        obs_req, obs_addr, obs_valid, obs_head, obs_instr, RPC);
            end
         end
         if (i == 1) begin
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
               errors++; $display("FAIL first_req got req=%b addr=%h exp 1/0", obs_req, obs_addr);
            end
         end
         if (i == 3) begin
            checks++;
            if (obs_valid !== 1'b1 || obs_head !== 32'h0) begin
               errors++; $display("FAIL first_valid got v=%b pc=%h exp 1/0", obs_valid, obs_head);
            end
         end
         if (i >= 3 && obs_valid === 1'b1) nvalid++;
      end
      checks++;
      if (nvalid != 9) begin
         errors++; $display("FAIL throughput got %0d valid cycles exp 9", nvalid);
      end
   endtask

   task automatic test_backpressure();
      int          nreq = 0;
      bit          resumed = 1'b0;
      logic [31:0] got[$];
      lat_min = 2; lat_max = 2;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL bp_stream cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
         if (obs_req === 1'b1) nreq++;
      end
      checks++;
      if (nreq != 4) begin
         errors++; $display("FAIL bp_req_count got %0d exp 4", nreq);
      end
      checks++;
      if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_head !== 32'h0) begin
         errors++; $display("FAIL bp_hold got req=%b v=%b pc=%h exp 0/1/0", obs_req, obs_valid, obs_head);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
         if (obs_valid === 1'b1) got.push_back(obs_head);
         if (obs_req === 1'b1) resumed = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (got.size() <= k) begin
            errors++; $display("FAIL bp_order_missing idx=%0d got %0d pops exp >=4", k, got.size());
         end else if (got[k] !== 32'(4 * k)) begin
            errors++; $display("FAIL bp_order idx=%0d got %h exp %h", k, got[k], 32'(4 * k));
         end
      end
      checks++;
      if (!resumed) begin
         errors++; $display("FAIL bp_resume got no request exp request");
      end
   endtask

   task automatic test_redirect_stale();
      int n = 0;
      bit first = 1'b1;
      lat_min = 3; lat_max = 3;
      do_reset();
      while (m_infl.size() != 2 && n < 10) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL rd_pre cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
         n++;
      end
      step(1'b0, 1'b1, 32'h100, 1'b1);
      checks++;
      if (obs_v !== exp_v || obs_req !== 1'b0) begin
         errors++; $display("FAIL rd_cycle cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
      end
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL rd_post cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
         if (i == 0) begin
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin
               errors++; $display("FAIL rd_new_req got req=%b addr=%h exp 1/100", obs_req, obs_addr);
            end
         end
         if (obs_valid === 1'b1) begin
            checks++;
            if ((first && obs_head !== 32'h100) || obs_head < 32'h100) begin
               errors++; $display("FAIL rd_stale_word got pc=%h exp >=100 (first 100)", obs_head);
            end
            first = 1'b0;
         end
      end
      checks++;
      if (first) begin
         errors++; $display("FAIL rd_timeout got no instruction exp pc 100");
      end
   endtask

   task automatic test_redirect_misc();
      bit first = 1'b1;
      lat_min = 1; lat_max = 1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL rm_pre cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
      end
      step(1'b0, 1'b1, 32'h203, 1'b1);
      checks++;
      if (obs_v !== exp_v || obs_valid !== 1'b1 || !obs_rsp) begin
         errors++; $display("FAIL rm_coincide cyc=%0d got=%h exp=%h rsp=%b", obs_cyc, obs_v, exp_v, obs_rsp);
      end
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h200) begin
         errors++; $display("FAIL rm_flush got v=%b req=%b addr=%h exp 0/1/200", obs_valid, obs_req, obs_addr);
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL rm_post cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
         if (first && obs_valid === 1'b1) begin
            checks++;
            if (obs_head !== 32'h200) begin
               errors++; $display("FAIL rm_first_pc got %h exp 200", obs_head);
            end
            first = 1'b0;
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] got[$];
      lat_min = 1; lat_max = 1;
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL wrap_stream cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
         if (obs_valid === 1'b1) got.push_back(obs_head);
      end
      checks++;
      if (got.size() < 2) begin
         errors++; $display("FAIL wrap_count got %0d exp >=2", got.size());
      end else if (got[0] !== 32'hFFFF_FFFC || got[1] !== 32'h0) begin
         errors++; $display("FAIL wrap_seq got %h,%h exp fffffffc,00000000", got[0], got[1]);
      end
   endtask

   task automatic test_reset_midop();
      int n = 0;
      bit first = 1'b1;
      lat_min = 1; lat_max = 1;
      do_reset();
      while (!(m_fifo.size() == 2 && m_infl.size() == 2) && n < 20) begin
         hold = (m_fifo.size() >= 2);
         step(1'b0, 1'b0, 32'h0, 1'b0);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL mr_fill cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
         n++;
      end
      checks++;
      if (m_fifo.size() != 2 || m_infl.size() != 2 || mq.size() != 2) begin
         errors++; $display("FAIL mr_setup got fifo=%0d infl=%0d mem=%0d exp 2/2/2",
                            m_fifo.size(), m_infl.size(), mq.size());
      end
      // Late responses land in the reset cycle and the BOOT cycle.
      foreach (mq[i]) mq[i].due = -1000;
      hold = 1'b0;
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (obs_req !== 1'b0 || obs_addr !== RPC || obs_valid !== 1'b0 ||
          obs_head !== 32'h0 || obs_instr !== 32'h0 || !obs_rsp) begin
         errors++;
         $display("FAIL mr_reset_vals got req=%b addr=%h v=%b pc=%h ins=%h rsp=%b exp 0/%h/0/0/0",
                  obs_req, obs_addr, obs_valid, obs_head, obs_instr, obs_rsp, RPC);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL mr_restart cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
         if (first && obs_valid === 1'b1) begin
            checks++;
            if (obs_head !== RPC) begin
               errors++; $display("FAIL mr_first_pc got %h exp %h", obs_head, RPC);
            end
            first = 1'b0;
         end
      end
   endtask

   task automatic test_random();
      int          pops = 0;
      bit          rv, rdy;
      logic [31:0] rpc;
      lat_min = 1; lat_max = 3;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         rdy  = ($urandom_range(3, 0) != 0);
         rv   = ($urandom_range(19, 0) == 0);
         rpc  = $urandom;
         if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
         hold = ($urandom_range(7, 0) == 0);
         step(1'b0, rv, rpc, rdy);
         checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL random cyc=%0d got=%h exp=%h", obs_cyc, obs_v, exp_v);
         end
         if (obs_valid === 1'b1 && rdy && !rv) pops++;
      end
      hold = 1'b0;
      checks++;
      if (pops < 50) begin
         errors++; $display("FAIL random_progress got %0d pops exp >=50", pops);
      end
   endtask

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
      hold = 1'b0; m_pc = RPC; m_run = 1'b0; cyc_n = 0; last_due = -1;
      lat_min = 1; lat_max = 1;
      @(posedge clk); #1;
      test_reset();
      test_backpressure();
      test_redirect_stale();
      test_redirect_misc();
      test_wrap();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
